// File: rtl/lsu_dmem_responder.sv
// lsu_dmem_responder: dcache-side responder for LSU load/store requests,
// backed by a local word-organised data memory (bench/bring-up stand-in).
// Each accepted request yields one tagged response after LATENCY cycles,
// and responses are queued in a credit-limited FIFO to absorb backpressure.
//
// Ports:
//   clk, rst (sync, active-high), flush (drop in-flight and queued responses)
//   req_*_i / req_ready_o : request channel (opcode, sign, size, addr, data, tag)
//   resp_*_o / resp_ready_i : response channel (tag, data, err)
//
// Optional feature macro: LSU_DMEM_ADDR_CHECK_EN
//   defined   -> nonzero address bits above the word index flag resp_err_o,
//                and an out-of-range store leaves memory untouched
//   undefined -> upper address bits alias silently, resp_err_o is always 0
module lsu_dmem_responder #(
   parameter int unsigned XLEN               = 64,
   parameter int unsigned VIRTUAL_ADDR_LEN   = 39,
   parameter int unsigned LSU_LSQ_SIZE_WIDTH = 3,
   parameter int unsigned MEM_DEPTH          = 256,
   parameter int unsigned LATENCY            = 2,
   parameter int unsigned RESP_FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_opcode_i,
   input  logic                          req_sign_i,
   input  logic [1:0]                    req_size_i,
   input  logic [VIRTUAL_ADDR_LEN-1:0]   req_addr_i,
   input  logic [XLEN-1:0]               req_data_i,
   input  logic [LSU_LSQ_SIZE_WIDTH-1:0] req_lsq_index_i,
   output logic                          resp_valid_o,
   input  logic                          resp_ready_i,
   output logic [LSU_LSQ_SIZE_WIDTH-1:0] resp_lsq_index_o,
   output logic [XLEN-1:0]               resp_data_o,
   output logic                          resp_err_o
);

   localparam int unsigned NBYTES = XLEN / 8;
   localparam int unsigned OFF_W  = $clog2(NBYTES);
   localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
   localparam int unsigned HI_W   = VIRTUAL_ADDR_LEN - OFF_W - IDX_W;
   localparam int unsigned PTR_W  = $clog2(RESP_FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   // The FIFO write is the final registered step, so the pipeline itself
   // needs one stage fewer than LATENCY.
   localparam int unsigned NSTG   = LATENCY - 1;

   typedef struct packed {
      logic [LSU_LSQ_SIZE_WIDTH-1:0] tag;
      logic [XLEN-1:0]               data;
      logic                          err;
   } rec_t;

   logic [XLEN-1:0]   mem_q [MEM_DEPTH];

   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic [HI_W-1:0]   addr_hi;
   logic [XLEN-1:0]   rd_sh;
   logic [XLEN-1:0]   ld_data;
   logic [NBYTES-1:0] be_base;
   logic [NBYTES-1:0] be;
   logic [XLEN-1:0]   wdata;
   logic              addr_err;
   logic              acc;
   rec_t              acc_rec;

   logic              push_v;
   rec_t              push_rec;
   logic [CNT_W-1:0]  pipe_cnt;

   logic [PTR_W-1:0]  wptr_q, rptr_q;
   logic [CNT_W-1:0]  cnt_q;
   rec_t              fifo_q [RESP_FIFO_DEPTH];
   rec_t              head;
   logic              pop;

   // Address decode, load extraction and store lane alignment
   always_comb begin
      off     = req_addr_i[OFF_W-1:0];
      idx     = req_addr_i[OFF_W +: IDX_W];
      addr_hi = req_addr_i[VIRTUAL_ADDR_LEN-1 -: HI_W];
      rd_sh   = mem_q[idx] >> {off, 3'b000};
      ld_data = rd_sh;
      be_base = '1;
      case (req_size_i)
         2'd0: begin
            ld_data = req_sign_i ? {{(XLEN-8){rd_sh[7]}}, rd_sh[7:0]}
                                 : {{(XLEN-8){1'b0}}, rd_sh[7:0]};
            be_base = NBYTES'(1);
         end
         2'd1: begin
            ld_data = req_sign_i ? {{(XLEN-16){rd_sh[15]}}, rd_sh[15:0]}
                                 : {{(XLEN-16){1'b0}}, rd_sh[15:0]};
            be_base = NBYTES'(3);
         end
         2'd2: begin
            ld_data = req_sign_i ? {{(XLEN-32){rd_sh[31]}}, rd_sh[31:0]}
                                 : {{(XLEN-32){1'b0}}, rd_sh[31:0]};
            be_base = NBYTES'(15);
         end
         2'd3: begin
            ld_data = rd_sh;
            be_base = '1;
         end
      endcase
      be    = be_base << off;
      wdata = req_data_i << {off, 3'b000};
   end

`ifdef LSU_DMEM_ADDR_CHECK_EN
   assign addr_err = |addr_hi;
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_hi;
   assign addr_err       = 1'b0;
`endif

   // Credits: pipeline occupancy plus FIFO count, crediting this cycle's pop
   assign pop          = resp_valid_o && resp_ready_i;
   assign req_ready_o  = !rst && !flush &&
                         ((pipe_cnt + cnt_q - CNT_W'(pop)) < CNT_W'(RESP_FIFO_DEPTH));
   assign acc          = req_valid_i && req_ready_o;

   always_comb begin
      acc_rec.tag  = req_lsq_index_i;
      acc_rec.data = (req_opcode_i || addr_err) ? '0 : ld_data;
      acc_rec.err  = addr_err;
   end

   // Store write in the accept cycle; memory is deliberately not reset
   always_ff @(posedge clk) begin
      if (acc && req_opcode_i && !addr_err) begin
         for (int unsigned b = 0; b < NBYTES; b++) begin
            if (be[b]) mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Fixed-latency response pipeline; never stalls thanks to the credit limit
   generate
      if (NSTG == 0) begin : g_direct
         assign push_v   = acc;
         assign push_rec = acc_rec;
         assign pipe_cnt = '0;
      end else begin : g_pipe
         logic [NSTG-1:0] stg_v_q;
         rec_t            stg_q [NSTG];

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               stg_v_q <= '0;
            end else begin
               stg_v_q[0] <= acc;
               for (int unsigned i = 1; i < NSTG; i++) stg_v_q[i] <= stg_v_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            stg_q[0] <= acc_rec;
            for (int unsigned i = 1; i < NSTG; i++) stg_q[i] <= stg_q[i-1];
         end

         assign push_v   = stg_v_q[NSTG-1];
         assign push_rec = stg_q[NSTG-1];
         assign pipe_cnt = CNT_W'($countones(stg_v_q));
      end
   endgenerate

   // FIFO pointers and count; flush wins over push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         rptr_q <= wptr_q;
         cnt_q  <= '0;
      end else begin
         if (push_v) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)    rptr_q <= rptr_q + PTR_W'(1);
         case ({push_v, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push_v) fifo_q[wptr_q] <= push_rec;
   end

   // Head entry drives the outputs; zeroed when the FIFO is empty
   assign head         = fifo_q[rptr_q];
   assign resp_valid_o = (cnt_q != '0);

   always_comb begin
      resp_lsq_index_o = '0;
      resp_data_o      = '0;
      resp_err_o       = 1'b0;
      if (resp_valid_o) begin
         resp_lsq_index_o = head.tag;
         resp_data_o      = head.data;
         resp_err_o       = head.err;
      end
   end

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// Directed self-checking bench for lsu_dmem_responder.
module tb_lsu_dmem_responder;

   localparam int unsigned XLEN = 64;
   localparam int unsigned VAL  = 39;
   localparam int unsigned TW   = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            req_valid_i;
   logic            req_ready_o;
   logic            req_opcode_i;
   logic            req_sign_i;
   logic [1:0]      req_size_i;
   logic [VAL-1:0]  req_addr_i;
   logic [XLEN-1:0] req_data_i;
   logic [TW-1:0]   req_lsq_index_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [TW-1:0]   resp_lsq_index_o;
   logic [XLEN-1:0] resp_data_o;
   logic            resp_err_o;

   typedef struct packed {
      logic [TW-1:0]   tag;
      logic [XLEN-1:0] data;
      logic            err;
   } rsp_t;

   rsp_t got_q[$];
   rsp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_acc = 0;

`ifdef LSU_DMEM_ADDR_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   lsu_dmem_responder #(
      .XLEN(XLEN), .VIRTUAL_ADDR_LEN(VAL), .LSU_LSQ_SIZE_WIDTH(TW),
      .MEM_DEPTH(256), .LATENCY(2), .RESP_FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_opcode_i(req_opcode_i), .req_sign_i(req_sign_i),
      .req_size_i(req_size_i), .req_addr_i(req_addr_i),
      .req_data_i(req_data_i), .req_lsq_index_i(req_lsq_index_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_lsq_index_o(resp_lsq_index_o), .resp_data_o(resp_data_o),
      .resp_err_o(resp_err_o)
   );

   // Record every handshake mid-cycle, where inputs and outputs are stable
   always @(negedge clk) begin
      if (!rst && resp_valid_o && resp_ready_i)
         got_q.push_back({resp_lsq_index_o, resp_data_o, resp_err_o});
      if (req_valid_i && req_ready_o) n_acc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
   endtask

   task automatic expect_rsp(input logic [TW-1:0] tag, input logic [XLEN-1:0] data, input logic err);
      exp_q.push_back({tag, data, err});
   endtask

   // Drive one request and hold it until accepted (bounded wait)
   task automatic send(input logic op, input logic sgn, input logic [1:0] sz,
                       input logic [VAL-1:0] addr, input logic [XLEN-1:0] data,
                       input logic [TW-1:0] tag);
      int w = 0;
      req_valid_i     = 1'b1;
      req_opcode_i    = op;
      req_sign_i      = sgn;
      req_size_i      = sz;
      req_addr_i      = addr;
      req_data_i      = data;
      req_lsq_index_i = tag;
      #1;
      while (!req_ready_o && w < 50) begin
         tick();
         w++;
      end
      if (!req_ready_o) chk("send_ready", 64'(req_ready_o), 64'd1);
      else              tick();
      req_valid_i = 1'b0;
   endtask

   task automatic compare_resps(input string name);
      int n;
      chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({name, "_tag"},  64'(got_q[i].tag), 64'(exp_q[i].tag));
         chk({name, "_data"}, got_q[i].data,     exp_q[i].data);
         chk({name, "_err"},  64'(got_q[i].err), 64'(exp_q[i].err));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   localparam logic [63:0] W10 = 64'h1122_3344_8066_7788;

   initial begin
      logic [63:0] wexp;
      rst = 1'b1; flush = 1'b0; resp_ready_i = 1'b1;
      req_valid_i = 1'b1; req_opcode_i = 1'b0; req_sign_i = 1'b0;
      req_size_i = 2'd3; req_addr_i = '0; req_data_i = '0; req_lsq_index_i = '0;
      drain(2);
      // Reset state
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_valid", 64'(resp_valid_o), 64'd0);
      chk("rst_data",  resp_data_o, 64'd0);
      chk("rst_tag",   64'(resp_lsq_index_o), 64'd0);
      chk("rst_err",   64'(resp_err_o), 64'd0);
      req_valid_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(req_ready_o), 64'd1);

      // Store then load dword, latency and read-after-write
      send(1'b1, 1'b0, 2'd3, 39'h10, 64'h1122_3344_5566_7788, 3'd1);
      chk("t1_valid_acc1", 64'(resp_valid_o), 64'd0);
      send(1'b0, 1'b1, 2'd3, 39'h10, 64'd0, 3'd2);
      chk("t1_valid_acc2", 64'(resp_valid_o), 64'd1);
      chk("t1_tag1", 64'(resp_lsq_index_o), 64'd1);
      chk("t1_data1", resp_data_o, 64'd0);
      tick();
      chk("t1_tag2", 64'(resp_lsq_index_o), 64'd2);
      chk("t1_data2", resp_data_o, 64'h1122_3344_5566_7788);
      tick();
      chk("t1_empty", 64'(resp_valid_o), 64'd0);
      got_q.delete();

      // Byte store and sub-word loads with sign/zero extension
      send(1'b1, 1'b0, 2'd0, 39'h13, 64'h80, 3'd3);            expect_rsp(3'd3, 64'd0, 1'b0);
      send(1'b0, 1'b1, 2'd0, 39'h13, 64'd0, 3'd4);             expect_rsp(3'd4, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      send(1'b0, 1'b0, 2'd0, 39'h13, 64'd0, 3'd5);             expect_rsp(3'd5, 64'h80, 1'b0);
      send(1'b0, 1'b0, 2'd2, 39'h10, 64'd0, 3'd6);             expect_rsp(3'd6, 64'h8066_7788, 1'b0);
      send(1'b0, 1'b1, 2'd2, 39'h10, 64'd0, 3'd7);             expect_rsp(3'd7, 64'hFFFF_FFFF_8066_7788, 1'b0);
      send(1'b0, 1'b1, 2'd1, 39'h12, 64'd0, 3'd0);             expect_rsp(3'd0, 64'hFFFF_FFFF_FFFF_8066, 1'b0);
      send(1'b0, 1'b0, 2'd3, 39'h10, 64'd0, 3'd1);             expect_rsp(3'd1, W10, 1'b0);
      drain(6);
      compare_resps("t2");

      // Backpressure: only four credits
      resp_ready_i = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         req_valid_i = 1'b1; req_opcode_i = 1'b0; req_sign_i = 1'b0;
         req_size_i = 2'd3; req_addr_i = 39'h10; req_lsq_index_i = TW'(i);
         tick();
      end
      req_valid_i = 1'b0;
      #1;
      chk("t3_accepts", 64'(n_acc), 64'd4);
      chk("t3_ready_full", 64'(req_ready_o), 64'd0);
      chk("t3_head_tag", 64'(resp_lsq_index_o), 64'd0);
      for (int i = 0; i < 4; i++) expect_rsp(TW'(i), W10, 1'b0);
      req_valid_i = 1'b1; req_lsq_index_i = 3'd6; resp_ready_i = 1'b1;
      #1;
      chk("t3_ready_on_pop", 64'(req_ready_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      expect_rsp(3'd6, W10, 1'b0);
      drain(10);
      compare_resps("t3");

      // Flush with responses in FIFO and pipeline
      resp_ready_i = 1'b0;
      send(1'b0, 1'b0, 2'd3, 39'h10, 64'd0, 3'd1);
      send(1'b0, 1'b0, 2'd3, 39'h10, 64'd0, 3'd2);
      send(1'b0, 1'b0, 2'd3, 39'h10, 64'd0, 3'd3);
      chk("t4_valid_pre", 64'(resp_valid_o), 64'd1);
      flush = 1'b1;
      req_valid_i = 1'b1; req_lsq_index_i = 3'd7;
      #1;
      chk("t4_ready_flush", 64'(req_ready_o), 64'd0);
      tick();
      flush = 1'b0; req_valid_i = 1'b0;
      chk("t4_valid_post", 64'(resp_valid_o), 64'd0);
      #1;
      chk("t4_ready_post", 64'(req_ready_o), 64'd1);
      resp_ready_i = 1'b1;
      drain(8);
      chk("t4_no_stale", 64'(got_q.size()), 64'd0);
      got_q.delete();
      send(1'b0, 1'b0, 2'd1, 39'h16, 64'd0, 3'd4);
      expect_rsp(3'd4, 64'h1122, 1'b0);
      drain(5);
      compare_resps("t4_after");

      // Continuous accept+pop, pointers wrap
      for (int i = 0; i < 20; i++) begin
         send(1'b0, 1'b0, 2'd0, VAL'(16 + (i % 8)), 64'd0, TW'(i % 8));
         wexp = (W10 >> (8 * (i % 8))) & 64'hFF;
         expect_rsp(TW'(i % 8), wexp, 1'b0);
      end
      drain(6);
      compare_resps("t5");

      // Upper address bits: error or alias depending on build
      send(1'b1, 1'b0, 2'd3, 39'h0, 64'h0123_4567_89AB_CDEF, 3'd0);
      expect_rsp(3'd0, 64'd0, 1'b0);
      send(1'b1, 1'b0, 2'd3, 39'h10_0000, 64'hDEAD_BEEF_CAFE_F00D, 3'd5);
      expect_rsp(3'd5, 64'd0, CHK_EN);
      send(1'b0, 1'b0, 2'd3, 39'h0, 64'd0, 3'd6);
      expect_rsp(3'd6, CHK_EN ? 64'h0123_4567_89AB_CDEF : 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
      send(1'b0, 1'b0, 2'd3, 39'h10_0000, 64'd0, 3'd7);
      expect_rsp(3'd7, CHK_EN ? 64'd0 : 64'hDEAD_BEEF_CAFE_F00D, CHK_EN);
      drain(6);
      compare_resps("t6");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
